// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage of the 16-bit SIMPLE core.
// Non-memory instructions pass straight to register write-back. Loads and
// stores run a request/ready handshake with data memory while stall holds
// the upstream stages.
// Optional feature macro: MEM_TIMEOUT_EN. It adds an access timeout that
// aborts the access after TIMEOUT_CYCLES cycles in ACCESS and sets a sticky
// bus_err flag.
//
//   state  | meaning
//   IDLE   | accepting one instruction per cycle from execute
//   ACCESS | data-memory access outstanding; upstream held, inputs ignored
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] alu_result,
    input  logic        write_reg,
    input  logic [2:0]  reg_addr,
    input  logic [15:0] mem_address,
    input  logic [15:0] store_data,
    input  logic        read_enable,
    input  logic        write_enable,
    output logic        dm_req,
    output logic        dm_we,
    output logic [15:0] dm_addr,
    output logic [15:0] dm_wdata,
    input  logic [15:0] dm_rdata,
    input  logic        dm_ready,
    output logic        stall,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        bus_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_mem_op;
    logic        w_timeout;
    logic        r_lat_write_reg;
    logic [2:0]  r_lat_reg_addr;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] LP_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0]  r_tmo_cnt;
    logic        r_bus_err;

    // Timeout fires on the ACCESS edge where the wait count reaches the limit;
    // a ready on that same edge takes priority.
    always_comb begin
        w_timeout = (r_state == ACCESS) && !dm_ready && (r_tmo_cnt == LP_TIMEOUT_LAST);
    end

    assign bus_err = r_bus_err;
`else
    logic [7:0]  w_unused_timeout;

    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign bus_err          = 1'b0;
`endif

    assign w_mem_op = read_enable | write_enable;
    assign stall    = (r_state == ACCESS);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (dm_ready || w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Memory request, write-back and latched-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_req          <= 1'b0;
            dm_we           <= 1'b0;
            dm_addr         <= 16'h0000;
            dm_wdata        <= 16'h0000;
            wb_en           <= 1'b0;
            wb_addr         <= 3'd0;
            wb_data         <= 16'h0000;
            r_lat_write_reg <= 1'b0;
            r_lat_reg_addr  <= 3'd0;
`ifdef MEM_TIMEOUT_EN
            r_tmo_cnt       <= 8'd0;
            r_bus_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        // A store wins when both enables are set.
                        dm_req          <= 1'b1;
                        dm_we           <= write_enable;
                        dm_addr         <= mem_address;
                        dm_wdata        <= store_data;
                        r_lat_write_reg <= write_reg;
                        r_lat_reg_addr  <= reg_addr;
                        wb_en           <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        r_tmo_cnt       <= 8'd0;
`endif
                    end else begin
                        // Write-back fields only move when a write actually happens.
                        wb_en <= write_reg;
                        if (write_reg) begin
                            wb_addr <= reg_addr;
                            wb_data <= alu_result;
                        end
                    end
                end
                ACCESS: begin
                    wb_en <= 1'b0;
                    if (dm_ready) begin
                        dm_req <= 1'b0;
                        if (!dm_we && r_lat_write_reg) begin
                            wb_en   <= 1'b1;
                            wb_addr <= r_lat_reg_addr;
                            wb_data <= dm_rdata;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (w_timeout) begin
                        dm_req    <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    dm_req <= 1'b0;
                    wb_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed cases followed by a randomized
// instruction stream. Expected results come from an instruction-level model
// (what each instruction must write back, and the last write-back fields).
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] alu_result;
    logic        write_reg;
    logic [2:0]  reg_addr;
    logic [15:0] mem_address;
    logic [15:0] store_data;
    logic        read_enable;
    logic        write_enable;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_ready;
    logic        stall;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        bus_err;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: last written-back register/data and the sticky error flag.
    logic [2:0]  exp_wb_addr;
    logic [15:0] exp_wb_data;
    logic        exp_bus_err;

    mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_result   (alu_result),
        .write_reg    (write_reg),
        .reg_addr     (reg_addr),
        .mem_address  (mem_address),
        .store_data   (store_data),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_ready     (dm_ready),
        .stall        (stall),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb_fields(input string tag);
        chk({tag, ".wb_addr"}, 16'(wb_addr), 16'(exp_wb_addr));
        chk({tag, ".wb_data"}, wb_data, exp_wb_data);
        chk({tag, ".bus_err"}, 16'(bus_err), 16'(exp_bus_err));
    endtask

    task automatic scramble_inputs();
        alu_result   = 16'($urandom);
        write_reg    = 1'($urandom);
        reg_addr     = 3'($urandom);
        mem_address  = 16'($urandom);
        store_data   = 16'($urandom);
        read_enable  = 1'($urandom);
        write_enable = 1'($urandom);
    endtask

    task automatic idle_inputs();
        scramble_inputs();
        write_reg    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
    endtask

    // Non-memory instruction; optional stray dm_ready while idle must be ignored.
    task automatic alu_op(input logic wr, input logic [2:0] ra, input logic [15:0] d,
                          input logic stray_ready);
        scramble_inputs();
        read_enable  = 1'b0;
        write_enable = 1'b0;
        write_reg    = wr;
        reg_addr     = ra;
        alu_result   = d;
        dm_ready     = stray_ready;
        dm_rdata     = 16'($urandom);
        @(negedge clk);
        dm_ready = 1'b0;
        if (wr) begin
            exp_wb_addr = ra;
            exp_wb_data = d;
        end
        chk("alu.stall", 16'(stall), 16'd0);
        chk("alu.dm_req", 16'(dm_req), 16'd0);
        chk("alu.wb_en", 16'(wb_en), 16'(wr));
        chk_wb_fields("alu");
    endtask

    // Load/store with dm_ready presented on ACCESS cycle 'lat' (lat >= 1).
    task automatic mem_op(input logic rd, input logic wr, input logic wreg,
                          input logic [2:0] ra, input logic [15:0] addr,
                          input logic [15:0] sd, input logic [15:0] rdat, input int lat);
        logic is_store;
        is_store = wr;
        scramble_inputs();
        read_enable  = rd;
        write_enable = wr;
        write_reg    = wreg;
        reg_addr     = ra;
        mem_address  = addr;
        store_data   = sd;
        dm_ready     = 1'b0;
        @(negedge clk);
        chk("mem.req0", 16'(dm_req), 16'd1);
        chk("mem.stall0", 16'(stall), 16'd1);
        chk("mem.we", 16'(dm_we), 16'(is_store));
        chk("mem.addr", dm_addr, addr);
        chk("mem.wdata", dm_wdata, sd);
        chk("mem.wb_en0", 16'(wb_en), 16'd0);
        scramble_inputs();
        for (int k = 1; k <= lat; k++) begin
            dm_ready = (k == lat);
            dm_rdata = (k == lat) ? rdat : 16'($urandom);
            @(negedge clk);
            if (k < lat) begin
                chk("mem.req_hold", 16'(dm_req), 16'd1);
                chk("mem.stall_hold", 16'(stall), 16'd1);
                chk("mem.addr_hold", dm_addr, addr);
                chk("mem.wdata_hold", dm_wdata, sd);
                chk("mem.we_hold", 16'(dm_we), 16'(is_store));
                chk("mem.wb_en_hold", 16'(wb_en), 16'd0);
            end
        end
        dm_ready = 1'b0;
        if (!is_store && wreg) begin
            exp_wb_addr = ra;
            exp_wb_data = rdat;
        end
        chk("mem.req_done", 16'(dm_req), 16'd0);
        chk("mem.stall_done", 16'(stall), 16'd0);
        chk("mem.wb_en_done", 16'(wb_en), 16'(!is_store && wreg));
        chk_wb_fields("mem.done");
    endtask

    initial begin
        rst_n       = 1'b0;
        dm_ready    = 1'b0;
        dm_rdata    = 16'h0000;
        exp_wb_addr = 3'd0;
        exp_wb_data = 16'h0000;
        exp_bus_err = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);

        // Reset values.
        chk("rst.dm_req", 16'(dm_req), 16'd0);
        chk("rst.dm_we", 16'(dm_we), 16'd0);
        chk("rst.dm_addr", dm_addr, 16'h0000);
        chk("rst.dm_wdata", dm_wdata, 16'h0000);
        chk("rst.stall", 16'(stall), 16'd0);
        chk("rst.wb_en", 16'(wb_en), 16'd0);
        chk_wb_fields("rst");
        rst_n = 1'b1;

        // Directed cases.
        alu_op(1'b1, 3'd3, 16'h1234, 1'b0);
        mem_op(1'b1, 1'b0, 1'b1, 3'd5, 16'h0040, 16'h0000, 16'hBEEF, 3);
        alu_op(1'b0, 3'd6, 16'h7777, 1'b0);
        mem_op(1'b0, 1'b1, 1'b1, 3'd2, 16'h0100, 16'h00AA, 16'h0000, 1);
        mem_op(1'b1, 1'b1, 1'b1, 3'd4, 16'h0200, 16'h5555, 16'hDEAD, 2);
        alu_op(1'b1, 3'd7, 16'hA5A5, 1'b0);
        alu_op(1'b1, 3'd1, 16'h0F0F, 1'b1);
        mem_op(1'b1, 1'b0, 1'b1, 3'd6, 16'hFFFF, 16'h1111, 16'hC0DE, 1);
        mem_op(1'b1, 1'b0, 1'b0, 3'd2, 16'h0002, 16'h2222, 16'h9999, 2);
        alu_op(1'b0, 3'd0, 16'h0000, 1'b0);

        // Access that never sees dm_ready.
        scramble_inputs();
        read_enable  = 1'b1;
        write_enable = 1'b0;
        write_reg    = 1'b1;
        reg_addr     = 3'd3;
        mem_address  = 16'h0300;
        @(negedge clk);
        chk("tmo.req0", 16'(dm_req), 16'd1);
        scramble_inputs();
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) chk("tmo.req_wait", 16'(dm_req), 16'd1);
        end
        exp_bus_err = 1'b1;
        chk("tmo.req_abort", 16'(dm_req), 16'd0);
        chk("tmo.stall_abort", 16'(stall), 16'd0);
        chk("tmo.wb_en", 16'(wb_en), 16'd0);
        chk_wb_fields("tmo");
        alu_op(1'b1, 3'd2, 16'h4242, 1'b0);
        alu_op(1'b0, 3'd5, 16'h0001, 1'b0);
`else
        for (int k = 1; k <= 100; k++) @(negedge clk);
        chk("tmo.req_c100", 16'(dm_req), 16'd1);
        chk("tmo.stall_c100", 16'(stall), 16'd1);
        chk("tmo.bus_err", 16'(bus_err), 16'd0);
        dm_ready = 1'b1;
        dm_rdata = 16'h3C3C;
        @(negedge clk);
        dm_ready    = 1'b0;
        exp_wb_addr = 3'd3;
        exp_wb_data = 16'h3C3C;
        chk("tmo.late_req", 16'(dm_req), 16'd0);
        chk("tmo.late_wb_en", 16'(wb_en), 16'd1);
        chk_wb_fields("tmo.late");
        alu_op(1'b0, 3'd5, 16'h0001, 1'b0);
`endif

        // Reset during the second ACCESS cycle.
        scramble_inputs();
        read_enable  = 1'b1;
        write_enable = 1'b0;
        write_reg    = 1'b1;
        reg_addr     = 3'd1;
        mem_address  = 16'h0ABC;
        @(negedge clk);
        scramble_inputs();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_wb_addr = 3'd0;
        exp_wb_data = 16'h0000;
        exp_bus_err = 1'b0;
        chk("mrst.dm_req", 16'(dm_req), 16'd0);
        chk("mrst.stall", 16'(stall), 16'd0);
        chk("mrst.wb_en", 16'(wb_en), 16'd0);
        chk("mrst.dm_addr", dm_addr, 16'h0000);
        chk_wb_fields("mrst");
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        alu_op(1'b1, 3'd6, 16'hCAFE, 1'b0);

        // Randomized instruction stream.
        for (int i = 0; i < 80; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: alu_op(1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom));
                1: mem_op(1'b1, 1'b0, 1'($urandom), 3'($urandom), 16'($urandom),
                          16'($urandom), 16'($urandom), int'($urandom_range(1, 4)));
                2: mem_op(1'b0, 1'b1, 1'($urandom), 3'($urandom), 16'($urandom),
                          16'($urandom), 16'($urandom), int'($urandom_range(1, 4)));
                default: mem_op(1'b1, 1'b1, 1'($urandom), 3'($urandom), 16'($urandom),
                                16'($urandom), 16'($urandom), int'($urandom_range(1, 4)));
            endcase
        end
        alu_op(1'b0, 3'd0, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
